// File: rtl/exu_stage.sv
// Execute stage: shared ALU, branch/jump resolution and a one-entry result buffer toward LSU/WBU.
// Latency: 1 cycle from accept to out_valid; the redirect pulse comes in the cycle after accept.
// Backpressure: in_ready = ~out_valid | out_ready, so an accept and a drain can happen in the same cycle.
module exu_stage #(
`ifdef RISCV64
    parameter int DATA_LEN = 64,
`else
    parameter int DATA_LEN = 32,
`endif
    parameter int CNT_LEN  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_pc,
    input  logic [DATA_LEN-1:0] in_src1,
    input  logic [DATA_LEN-1:0] in_src2,
    input  logic [DATA_LEN-1:0] in_imm,
    input  logic [3:0]          in_op,
    input  logic                in_use_imm,
    input  logic                in_use_pc,
    input  logic                in_is_br,
    input  logic                in_is_jal,
    input  logic                in_is_jalr,
    input  logic [4:0]          in_rd,
    input  logic                in_wen,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_res,
    output logic [4:0]          out_rd,
    output logic                out_wen,
    output logic                redir_valid,
    output logic [DATA_LEN-1:0] redir_pc,
    output logic [CNT_LEN-1:0]  retired_cnt
);

    localparam int SH_W = $clog2(DATA_LEN);

    logic                accept;
    logic                is_jump;
    logic                take;
    logic                br_taken;
    logic                flag_eq;
    logic                flag_lt;
    logic                flag_ltu;
    logic [3:0]          alu_op;
    logic [SH_W-1:0]     shamt;
    logic [DATA_LEN-1:0] alu_a;
    logic [DATA_LEN-1:0] alu_b;
    logic [DATA_LEN-1:0] alu_res;
    logic [DATA_LEN:0]   sub_w;
    logic [DATA_LEN-1:0] tgt_sum;
    logic [DATA_LEN-1:0] tgt;
    logic [DATA_LEN-1:0] link;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        is_jump = in_is_jal | in_is_jalr;
        // Branches always compare rs1 against rs2, whatever the operand selects say.
        alu_a   = (in_use_pc & ~in_is_br) ? in_pc : in_src1;
        alu_b   = (in_use_imm & ~in_is_br) ? in_imm : in_src2;
        alu_op  = (in_is_br | is_jump) ? 4'b1000 : in_op;
        shamt   = alu_b[SH_W-1:0];

        // The extra MSB of the subtraction is the unsigned borrow.
        sub_w    = {1'b0, alu_a} - {1'b0, alu_b};
        flag_eq  = (alu_a == alu_b);
        flag_ltu = sub_w[DATA_LEN];
        flag_lt  = (alu_a[DATA_LEN-1] != alu_b[DATA_LEN-1]) ? alu_a[DATA_LEN-1] : sub_w[DATA_LEN-1];

        case (alu_op[2:0])
            3'b000:  alu_res = alu_op[3] ? sub_w[DATA_LEN-1:0] : alu_a + alu_b;
            3'b001:  alu_res = alu_a << shamt;
            3'b010:  alu_res = {{(DATA_LEN-1){1'b0}}, flag_lt};
            3'b011:  alu_res = {{(DATA_LEN-1){1'b0}}, flag_ltu};
            3'b100:  alu_res = alu_a ^ alu_b;
            3'b101:  alu_res = alu_op[3] ? DATA_LEN'($signed(alu_a) >>> shamt) : alu_a >> shamt;
            3'b110:  alu_res = alu_a | alu_b;
            default: alu_res = alu_a & alu_b;
        endcase

        case (in_op[2:0])
            3'b000:  br_taken = flag_eq;
            3'b001:  br_taken = ~flag_eq;
            3'b100:  br_taken = flag_lt;
            3'b101:  br_taken = ~flag_lt;
            3'b110:  br_taken = flag_ltu;
            3'b111:  br_taken = ~flag_ltu;
            default: br_taken = 1'b0;
        endcase

        take    = is_jump | (in_is_br & br_taken);
        // Target adder is separate from the ALU so a branch can compare and compute its target together.
        tgt_sum = (in_is_jalr ? in_src1 : in_pc) + in_imm;
        tgt     = {tgt_sum[DATA_LEN-1:1], tgt_sum[0] & ~in_is_jalr};
        link    = in_pc + DATA_LEN'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_res     <= '0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            retired_cnt <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_res   <= is_jump ? link : alu_res;
                out_rd    <= in_rd;
                out_wen   <= in_wen & (in_rd != 5'd0) & ~in_is_br;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            redir_valid <= accept & take;
            if (accept & take) begin
                redir_pc <= tgt;
            end

            if (out_valid & out_ready) begin
                retired_cnt <= retired_cnt + CNT_LEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_exu_stage.sv
// Scoreboard bench for exu_stage: the stimulus pushes expected beats and redirects, and a monitor pops them.
module tb_exu_stage;

    localparam logic [4:0] F_IMM  = 5'b10000;
    localparam logic [4:0] F_PC   = 5'b01000;
    localparam logic [4:0] F_BR   = 5'b00100;
    localparam logic [4:0] F_JAL  = 5'b00010;
    localparam logic [4:0] F_JALR = 5'b00001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_src1, in_src2, in_imm;
    logic [3:0]  in_op;
    logic        in_use_imm, in_use_pc, in_is_br, in_is_jal, in_is_jalr;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        out_valid, out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [63:0] retired_cnt;

    exu_stage #(.DATA_LEN(32), .CNT_LEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
        .in_op(in_op), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
        .in_is_br(in_is_br), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
        .in_rd(in_rd), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_rd(out_rd), .out_wen(out_wen),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t        oq[$];
    logic [31:0] rq[$];
    exp_t        mon_e;
    logic [31:0] mon_pc;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out after 50 cycles, expected completion", name);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (oq.size() == 0) begin
                check("out_unexpected", 64'(out_res), 64'hDEAD_BEEF_0000_0000);
            end else begin
                mon_e = oq.pop_front();
                check("out_res", 64'(out_res), 64'(mon_e.res));
                check("out_rd",  64'(out_rd),  64'(mon_e.rd));
                check("out_wen", 64'(out_wen), 64'(mon_e.wen));
            end
        end
        if (rst_n && redir_valid) begin
            if (rq.size() == 0) begin
                check("redir_unexpected", 64'(redir_pc), 64'hDEAD_BEEF_0000_0000);
            end else begin
                mon_pc = rq.pop_front();
                check("redir_pc", 64'(redir_pc), 64'(mon_pc));
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] imm, input logic [3:0] op, input logic [4:0] fl,
                        input logic [4:0] rd, input logic wen,
                        input logic [31:0] eres, input logic ewen,
                        input logic eredir, input logic [31:0] erpc);
        exp_t e;
        logic rdy;
        bit   acc;
        in_pc = pc; in_src1 = s1; in_src2 = s2; in_imm = imm; in_op = op;
        {in_use_imm, in_use_pc, in_is_br, in_is_jal, in_is_jalr} = fl;
        in_rd = rd; in_wen = wen; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) acc = 1'b1;
        end
        if (!acc) begin
            timeout_fail("accept");
        end else begin
            e.res = eres; e.rd = rd; e.wen = ewen;
            oq.push_back(e);
            if (eredir) rq.push_back(erpc);
        end
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        {in_use_imm, in_use_pc, in_is_br, in_is_jal, in_is_jalr} = 5'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!out_valid) done = 1'b1;
        end
        if (!done) timeout_fail("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        logic [63:0] cnt0;
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        in_pc = '0; in_src1 = '0; in_src2 = '0; in_imm = '0; in_op = '0;
        in_use_imm = 0; in_use_pc = 0; in_is_br = 0; in_is_jal = 0; in_is_jalr = 0;
        in_rd = '0; in_wen = 0;

        #2 rst_n = 1'b0;
        #10;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_res", 64'(out_res), 0);
        check("rst_out_rd", 64'(out_rd), 0);
        check("rst_out_wen", 64'(out_wen), 0);
        check("rst_redir_valid", 64'(redir_valid), 0);
        check("rst_redir_pc", 64'(redir_pc), 0);
        check("rst_retired_cnt", retired_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check("rst_in_ready", 64'(in_ready), 1);

        // ALU ops back to back; three beats must take exactly three cycles
        c0 = cyc;
        send(0, 5, 7, 0, 4'b0000, 5'b0, 3, 1, 32'd12, 1, 0, 0);
        send(0, 5, 7, 0, 4'b1000, 5'b0, 4, 1, 32'hFFFF_FFFE, 1, 0, 0);
        send(0, 6, 7, 0, 4'b1000, 5'b0, 5, 1, 32'hFFFF_FFFF, 1, 0, 0);
        check("throughput_cycles", 64'(cyc - c0), 3);
        send(32'h1000, 0, 0, 32'h2000, 4'b0000, F_IMM | F_PC, 2, 1, 32'h3000, 1, 0, 0);
        send(0, 32'hFFFF_FFFF, 1, 0, 4'b0010, 5'b0, 6, 1, 32'd1, 1, 0, 0);
        send(0, 32'hFFFF_FFFF, 1, 0, 4'b0011, 5'b0, 6, 1, 32'd0, 1, 0, 0);
        send(0, 32'h0000_F0F0, 32'h0000_FF00, 0, 4'b0100, 5'b0, 7, 1, 32'h0000_0FF0, 1, 0, 0);
        send(0, 1, 0, 33, 4'b0001, F_IMM, 8, 1, 32'd2, 1, 0, 0);
        drain();

        // Backpressure: buffer holds A while B waits; both drain in order
        out_ready = 1'b0;
        send(0, 1, 2, 0, 4'b0000, 5'b0, 7, 1, 32'd3, 1, 0, 0);
        fork
            send(0, 32'hFF, 32'h0F, 0, 4'b0111, 5'b0, 8, 1, 32'h0F, 1, 0, 0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 0);
                    check("bp_out_valid", 64'(out_valid), 1);
                    check("bp_out_res", 64'(out_res), 3);
                end
                cnt0 = retired_cnt;
                @(posedge clk) #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_retired_delta", retired_cnt - cnt0, 2);

        // Branches: signed vs unsigned compare, eq, ge
        send(32'h100, 32'h8000_0000, 1, 32'h40, 4'b0100, F_BR, 5, 1, 32'h7FFF_FFFF, 0, 1, 32'h140);
        send(32'h100, 32'h8000_0000, 1, 32'h40, 4'b0110, F_BR, 5, 1, 32'h7FFF_FFFF, 0, 0, 0);
        send(32'h300, 9, 9, 32'hFFFF_FFF8, 4'b0000, F_BR, 5, 1, 32'h0, 0, 1, 32'h2F8);
        send(32'h300, 32'h8000_0000, 1, 32'h40, 4'b0101, F_BR, 5, 1, 32'h7FFF_FFFF, 0, 0, 0);
        idle(3);

        // Jumps: JALR clears bit 0, JAL link wraps
        send(32'h8000_0000, 32'h1001, 0, 2, 4'b0000, F_JALR, 1, 1, 32'h8000_0004, 1, 1, 32'h1002);
        send(32'hFFFF_FFFC, 0, 0, 8, 4'b0000, F_JAL, 1, 1, 32'h0, 1, 1, 32'h4);
        idle(3);

        // Shifts; rd=0 suppresses the write
        send(0, 32'h8000_0000, 0, 31, 4'b1101, F_IMM, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        send(0, 32'h8000_0000, 0, 31, 4'b0101, F_IMM, 2, 1, 32'h1, 1, 0, 0);
        drain();
        check("retired_total", retired_cnt, 18);

        // Reset while a beat is buffered and a redirect is in flight
        out_ready = 1'b0;
        send(32'h200, 0, 0, 32'h10, 4'b0000, F_JAL, 1, 1, 32'h204, 1, 1, 32'h210);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 0);
        check("mid_rst_out_res", 64'(out_res), 0);
        check("mid_rst_out_wen", 64'(out_wen), 0);
        check("mid_rst_redir_valid", 64'(redir_valid), 0);
        check("mid_rst_redir_pc", 64'(redir_pc), 0);
        check("mid_rst_retired", retired_cnt, 0);
        oq.delete();
        rq.delete();
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 1);
        @(posedge clk) #1;
        send(0, 2, 3, 0, 4'b0000, 5'b0, 9, 1, 32'd5, 1, 0, 0);
        drain();
        idle(2);

        check("out_queue_empty", 64'(oq.size()), 0);
        check("redir_queue_empty", 64'(rq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
